// File: rtl/lfsr_rng_gen.sv
// Request-driven pseudo-random draw engine built on a Fibonacci LFSR.
// Define LFSR_RNG_REJECT_EN to enable range limiting by rejection sampling.
module lfsr_rng_gen #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                OUT_W     = 4,
  parameter int                STEP      = 16,
  parameter int                MAX_VAL   = 11,
  parameter int                MAX_TRIES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              req,
  output logic              busy,
  output logic              rnd_valid,
  output logic [OUT_W-1:0]  rnd
);

  localparam int CNT_W = $clog2(STEP + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

`ifdef LFSR_RNG_REJECT_EN
  localparam bit REJECT_EN = 1'b1;
`else
  localparam bit REJECT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  rnd_q, rnd_d;
  logic              rnd_valid_q, rnd_valid_d;

  logic [OUT_W-1:0]  cand;
  logic              accept;
  logic [OUT_W-1:0]  accept_val;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & TAPS)};
  endfunction

  // Out-of-range candidates are retried; the final attempt clamps to MAX_VAL.
  function automatic logic [OUT_W-1:0] clamp_val(input logic [OUT_W-1:0] c);
    if (REJECT_EN && (c > OUT_W'(MAX_VAL))) return OUT_W'(MAX_VAL);
    return c;
  endfunction

  assign cand       = lfsr_q[LFSR_W-1 -: OUT_W];
  assign accept     = !REJECT_EN || (cand <= OUT_W'(MAX_VAL)) ||
                      (tries_q == TRY_W'(MAX_TRIES - 1));
  assign accept_val = clamp_val(cand);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tries_q     <= '0;
      lfsr_q      <= SEED;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      lfsr_q      <= lfsr_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tries_d     = tries_q;
    lfsr_d      = lfsr_q;
    rnd_d       = rnd_q;
    rnd_valid_d = 1'b0;
    if (seed_load) begin
      // Reseeding aborts any draw in flight; a zero seed would lock the LFSR.
      lfsr_d  = (seed_in == '0) ? SEED : seed_in;
      state_d = IDLE;
    end else begin
      if (lfsr_q == '0) begin
        lfsr_d = SEED;
      end else if (state_q == SHIFT) begin
        lfsr_d = lfsr_next(lfsr_q);
      end
      case (state_q)
        IDLE: begin
          if (req) begin
            state_d = SHIFT;
            cnt_d   = '0;
            tries_d = '0;
          end
        end
        SHIFT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STEP - 1)) state_d = CHECK;
        end
        CHECK: begin
          if (accept) begin
            rnd_d       = accept_val;
            rnd_valid_d = 1'b1;
            state_d     = IDLE;
          end else begin
            tries_d = tries_q + TRY_W'(1);
            cnt_d   = '0;
            state_d = SHIFT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    rnd_valid = rnd_valid_q;
    rnd       = rnd_q;
  end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// Scoreboard bench for lfsr_rng_gen: a draw-level reference model predicts each
// delivered value and its delivery cycle; a monitor checks every rnd_valid pulse.
module tb_lfsr_rng_gen;

  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] TAPS  = 16'hB400;
  localparam int          STEP  = 16;
  localparam int          MAXV  = 3;
  localparam int          TRIES = 4;
`ifdef LFSR_RNG_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;
  logic        busy;
  logic        rnd_valid;
  logic [3:0]  rnd;

  lfsr_rng_gen #(
    .LFSR_W(16), .TAPS(TAPS), .SEED(SEED), .OUT_W(4), .STEP(STEP),
    .MAX_VAL(MAXV), .MAX_TRIES(TRIES)
  ) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .busy(busy), .rnd_valid(rnd_valid), .rnd(rnd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] val;
    int         at;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr;
  logic [3:0]  last_rnd;
  int          n_forced = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one LFSR step as the spec defines it, then whole draws.
  function automatic logic [15:0] m_step(input logic [15:0] s);
    if (s == 16'h0) return SEED;
    return {s[14:0], ^(s & TAPS)};
  endfunction

  task automatic model_draw(output logic [3:0] v, output int lat);
    logic [3:0] c;
    v   = 4'd0;
    lat = 0;
    for (int t = 0; t < TRIES; t++) begin
      for (int k = 0; k < STEP; k++) m_lfsr = m_step(m_lfsr);
      c   = m_lfsr[15:12];
      lat = (t + 1) * (STEP + 1);
      if (!REJ || c <= MAXV) begin
        v = c;
        return;
      end
      if (t == TRIES - 1) begin
        v = 4'(MAXV);
        n_forced++;
      end
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rnd_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid actual=pulse rnd=%0d expected=no pending draw (cycle %0d)",
                 rnd, cyc);
      end else begin
        e = sb.pop_front();
        check("rnd_value", int'(rnd), int'(e.val));
        check("rnd_latency_cycle", cyc, e.at);
        check("busy_low_at_valid", int'(busy), 0);
`ifdef LFSR_RNG_REJECT_EN
        check("rnd_le_max_val", int'(rnd <= MAXV), 1);
`endif
      end
    end
  end

  // Issue n draws with req held high; called and returns at a falling edge.
  task automatic run_draws(input int n);
    int         start;
    int         fin;
    int         lat;
    logic [3:0] v;
    start = cyc + 1;
    req   = 1'b1;
    for (int i = 0; i < n; i++) begin
      model_draw(v, lat);
      fin = start + lat;
      sb.push_back('{v, fin});
      last_rnd = v;
      while (cyc < start) @(negedge clk);
      check("busy_after_req", int'(busy), 1);
      if (i == n - 1) req = 1'b0;
      while (cyc < fin - 1) @(negedge clk);
      check("busy_before_valid", int'(busy), 1);
      while (cyc < fin) @(negedge clk);
      start = fin + 1;
    end
  endtask

  task automatic do_seed(input logic [15:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    @(negedge clk);
    seed_load = 1'b0;
    m_lfsr    = (s == 16'h0) ? SEED : s;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst       = 1'b1;
    req       = 1'b0;
    seed_load = 1'b0;
    seed_in   = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_rnd", int'(rnd), 0);
    check("reset_rnd_valid", int'(rnd_valid), 0);
    rst      = 1'b0;
    m_lfsr   = SEED;
    last_rnd = 4'd0;
    @(negedge clk);

    run_draws(1);
    run_draws(5);
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      run_draws($urandom_range(1, 3));
    end

    // Asynchronous reset in the middle of a draw.
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check("rnd_before_rst", int'(rnd), int'(last_rnd));
    rst = 1'b1;
    #1;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_rnd", int'(rnd), 0);
    check("rst_mid_rnd_valid", int'(rnd_valid), 0);
    @(negedge clk);
    rst      = 1'b0;
    m_lfsr   = SEED;
    last_rnd = 4'd0;
    @(negedge clk);
    run_draws(1);

    // Reseed aborts a draw in flight; a same-cycle req is ignored.
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (7) @(negedge clk);
    req = 1'b1;
    do_seed(16'h0001);
    req = 1'b0;
    check("busy_after_reseed", int'(busy), 0);
    check("rnd_hold_reseed", int'(rnd), int'(last_rnd));
    repeat (25) @(negedge clk);
    check("busy_idle_after_abort", int'(busy), 0);
    run_draws(2);

    do_seed(16'h0000);
    run_draws(2);
    for (int r = 0; r < 3; r++) begin
      do_seed(16'($urandom_range(1, 65535)));
      run_draws($urandom_range(1, 3));
    end

    // Zero guard: deposit an all-zero state while idle.
    do_seed(16'h0000);
    force dut.lfsr_q = 16'h0000;
    #1;
    release dut.lfsr_q;
    @(negedge clk);
    check("zero_guard_lfsr", int'(dut.lfsr_q), int'(SEED));
    m_lfsr = SEED;
    run_draws(1);

    for (int r = 0; r < 12; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_draws($urandom_range(10, 20));
    end

    repeat (30) @(negedge clk);
    check("pending_draws", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_rng_gen.md
Name: lfsr_rng_gen

Overview:
- Parametrised pseudo-random draw engine for note/lane generation in game logic.
- Fibonacci LFSR of configurable width and taps; produces one OUT_W-bit value per request over a req/valid handshake.
- Optional range limiting by rejection sampling; run-time reseed; all-zero lock-up guard.
- Sits between the game FSM (issues req) and the note spawner (consumes rnd on rnd_valid).

Parameters:
- LFSR_W, 16, LFSR state width (≥ OUT_W+1, ≤ 32).
- TAPS, 16'hB400, tap mask; feedback = XOR-reduce(state & TAPS).
- SEED, 16'hACE1, reset/fallback seed; must be non-zero.
- OUT_W, 4, output value width.
- STEP, 16, LFSR shifts per draw attempt (1..LFSR_W).
- MAX_VAL, 11, largest accepted value (rejection sampling only).
- MAX_TRIES, 4, rejection attempts before forced accept.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- seed_load  in  1  load seed_in into LFSR this edge
- seed_in  in  LFSR_W  new seed
- req  in  1  request one draw; sampled only in IDLE
- busy  out  1  draw in progress (state ≠ IDLE)
- rnd_valid  out  1  one-cycle pulse, rnd updated
- rnd  out  OUT_W  last delivered value, held between draws

Behaviour:
- Reset (async): lfsr=SEED, state=IDLE, cnt=0, tries=0, rnd=0, rnd_valid=0, busy=0.
- Shift: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}; candidate = lfsr[LFSR_W-1 -: OUT_W].
- FSM states: IDLE, SHIFT, CHECK.
- IDLE: req=1 -> SHIFT, cnt=0, tries=0. Otherwise stay; LFSR holds (no free-running).
- SHIFT: shift every edge, cnt++. The edge performing shift number STEP -> CHECK.
- CHECK, accept: rnd <= candidate, rnd_valid=1 for exactly one cycle, -> IDLE.
- CHECK, reject: tries++, cnt=0, -> SHIFT.
- Latency: req sampled at edge k -> rnd_valid high after edge k+STEP+1 (17 cycles at defaults) when the first attempt is accepted. Each rejection adds STEP+1 cycles.
- busy is high in SHIFT and CHECK. It falls on the same edge that raises rnd_valid.
- req while busy is ignored, not queued. req held high in IDLE starts back-to-back draws; the next draw starts the cycle after rnd_valid.
- seed_load has priority over everything except rst:
  - lfsr <= seed_in, or SEED if seed_in==0.
  - state -> IDLE; any in-flight draw is aborted without rnd_valid.
  - rnd holds its value.
  - req in the same cycle is ignored.
- Zero guard: if lfsr is ever all-zero at an edge, load SEED instead of shifting.
- rnd and rnd_valid are registered outputs.

Optional Feature:
- Macro: LFSR_RNG_REJECT_EN.
- Defined, CHECK accepts when:
  - candidate ≤ MAX_VAL -> rnd = candidate; or
  - tries == MAX_TRIES-1 -> forced accept, rnd = MAX_VAL.
- Defined: max latency is MAX_TRIES*(STEP+1) cycles, and rnd never exceeds MAX_VAL.
- Undefined: CHECK always accepts. MAX_VAL and MAX_TRIES are unused. Fixed latency STEP+1.

Test Plan:
- Reset mid-draw: assert rst during SHIFT -> same cycle rnd=0, busy=0, rnd_valid=0; next req draws from SEED 16'hACE1.
- Single draw (macro off, defaults): req one cycle -> busy high 17 cycles; rnd_valid pulses exactly once, 17 cycles after req edge; rnd equals top 4 bits of golden LFSR model after 16 shifts from 16'hACE1.
- Back-to-back: req held high 5 draws -> 5 pulses spaced 18 cycles apart; values match golden sequence; req while busy causes no extra draw.
- Reseed: seed_load with seed_in=16'h0001 mid-draw -> no rnd_valid for the aborted draw; next draw matches golden from 16'h0001. seed_in=0 -> behaves as SEED.
- Rejection (macro on, MAX_VAL=3, MAX_TRIES=4): 200 draws -> every rnd ≤ 3; each latency is in {17,34,51,68}; forced accepts yield rnd=3; counts match golden model.
- Zero guard: force lfsr=0 via hierarchical deposit -> next edge lfsr=16'hACE1; no lock-up.
